// File: rtl/bus_arbiter_rr_if.sv
// Common-bus arbitration interface: requester-side requests and arbiter-side grant/select outputs.
// Latency: none (pure wiring bundle).
// Backpressure: none; requesters hold REQ level until they see GNT.
interface bus_arbiter_rr_if #(
  parameter int NREQ  = 4,
  parameter int DST_W = 16
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ-1:0]       LOCK;
  logic [4*NREQ-1:0]     SRC;
  logic [DST_W*NREQ-1:0] DST;
  logic [NREQ-1:0]       GNT;
  logic [3:0]            BUS_SEL;
  logic [DST_W-1:0]      DST_LD;
  logic                  BUSY;
  logic                  HOLD_ERR;

  // Requester side drives requests and routing, observes the grant.
  modport master (
    output REQ, LOCK, SRC, DST,
    input  GNT, BUS_SEL, DST_LD, BUSY, HOLD_ERR
  );

  // Arbiter side samples requests, drives grant, bus select and load strobes.
  modport slave (
    input  REQ, LOCK, SRC, DST,
    output GNT, BUS_SEL, DST_LD, BUSY, HOLD_ERR
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner arbiter for the 16-source common bus, with bounded bus lock.
// Latency: REQ sampled at edge k -> GNT/BUS_SEL/BUSY registered from edge k; DST_LD combinational.
// Backpressure: requesters wait on REQ until granted; a locked owner is force-released after MAX_HOLD HOLD cycles.
module bus_arbiter_rr #(
  parameter int NREQ     = 4,
  parameter int DST_W    = 16,
  parameter int MAX_HOLD = 8
) (
  input logic               CLK,
  input logic               RST_N,
  bus_arbiter_rr_if.slave   bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [3:0]      r_bus_sel;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      r_hold_cnt;
  logic            r_hold_err;
  // Requesters that were force-released and have not yet dropped LOCK.
  logic [NREQ-1:0] r_blk;

  logic            w_own_req;
  logic            w_own_lock;
  logic            w_hold_exp;
  logic            w_keep;
  logic            w_force;
  logic            w_release;
  logic [PW-1:0]   w_ptr_inc;
  logic [PW-1:0]   w_ptr_arb;
  logic [NREQ-1:0] w_blk_nxt;
  logic [NREQ-1:0] w_elig;
  logic            w_win_vld;
  logic [PW-1:0]   w_win;
  logic [3:0]      w_win_src;
  logic [DST_W-1:0] w_dst_ld;

  // Decide whether the current owner keeps the bus, releases, or is force-released.
  always_comb begin
    w_own_req  = bus.REQ[r_owner];
    w_own_lock = bus.LOCK[r_owner];
    w_hold_exp = (r_state == S_HOLD) && (r_hold_cnt >= 8'(MAX_HOLD));
    w_keep     = (r_state != S_IDLE) && w_own_req && w_own_lock && !w_hold_exp;
    w_force    = (r_state == S_HOLD) && w_own_req && w_own_lock && w_hold_exp;
    w_release  = (r_state != S_IDLE) && !w_keep;
    w_ptr_inc  = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);
    // On release the search restarts just past the old owner, making it last in line.
    w_ptr_arb  = w_release ? w_ptr_inc : r_ptr;
    w_blk_nxt  = (r_blk & bus.LOCK) | (w_force ? (NREQ'(1) << r_owner) : '0);
    w_elig     = bus.REQ & ~w_blk_nxt;
  end

  // Round-robin search: first eligible requester starting at the arbitration pointer.
  always_comb begin : arb_search
    int idx;
    idx       = 0;
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(w_ptr_arb) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_win_vld && w_elig[idx]) begin
        w_win_vld = 1'b1;
        w_win     = PW'(idx);
      end
    end
  end

  // Source code of the arbitration winner, latched onto BUS_SEL at the grant edge.
  always_comb begin
    w_win_src = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) w_win_src = bus.SRC[4*i +: 4];
    end
  end

  // Owner FSM: all grant-side outputs are registered here; reset clears them asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_bus_sel  <= 4'd0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_hold_cnt <= 8'd0;
      r_hold_err <= 1'b0;
      r_blk      <= '0;
    end else begin
      r_ptr      <= w_ptr_arb;
      r_blk      <= w_blk_nxt;
      r_hold_err <= w_force;
      if (w_keep) begin
        // BUS_SEL and GNT stay frozen while the owner holds the bus.
        r_state    <= S_HOLD;
        r_hold_cnt <= (r_state == S_GRANT) ? 8'd1 : r_hold_cnt + 8'd1;
      end else if (w_win_vld) begin
        r_state    <= S_GRANT;
        r_owner    <= w_win;
        r_gnt      <= NREQ'(1) << w_win;
        r_bus_sel  <= w_win_src;
        r_hold_cnt <= 8'd0;
      end else begin
        r_state    <= S_IDLE;
        r_gnt      <= '0;
        r_bus_sel  <= 4'd0;
        r_hold_cnt <= 8'd0;
      end
    end
  end

  // Load strobes follow the owner's live destination vector, gated by the grant.
  always_comb begin
    w_dst_ld = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dst_ld = w_dst_ld | (bus.DST[DST_W*i +: DST_W] & {DST_W{r_gnt[i]}});
    end
  end

  assign bus.GNT      = r_gnt;
  assign bus.BUS_SEL  = r_bus_sel;
  assign bus.DST_LD   = w_dst_ld;
  assign bus.BUSY     = |r_gnt;
  assign bus.HOLD_ERR = r_hold_err;

endmodule
